// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM LED driver.
package pwm_pkg;

    localparam logic MODE_STATIC  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Write port and pin outputs of pwm_multi, bundled for control-side and driver-side use.
interface pwm_multi_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned WIDTH = 8
);
    import pwm_pkg::*;

    localparam int unsigned CHW = ch_width(NCH);

    logic             wr_en;
    logic [CHW-1:0]   wr_ch;
    logic [WIDTH-1:0] wr_duty;
    logic             wr_mode;
    logic [NCH-1:0]   pwm_out;
    logic             period_start;

    modport master (
        output wr_en, wr_ch, wr_duty, wr_mode,
        input  pwm_out, period_start
    );

    modport slave (
        input  wr_en, wr_ch, wr_duty, wr_mode,
        output pwm_out, period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, period boundary and breathe-step tick.
module pwm_timebase #(
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BREATH_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary,
    output logic             breath_tick,
    output logic             period_start
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BREATH_LAST = BW'(BREATH_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    breath_q, breath_d;
    logic             ps_q, ps_d;
    logic             tick;

    assign tick        = (presc_q == PRESC_LAST);
    // The wrap tick max->0 is the only point where shadowed settings may go live.
    assign boundary    = tick && (cnt_q == '1);
    assign breath_tick = boundary && (breath_q == BREATH_LAST);

    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        breath_d = breath_q;
        if (boundary) begin
            breath_d = (breath_q == BREATH_LAST) ? '0 : breath_q + 1'b1;
        end
        ps_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            breath_q <= '0;
            ps_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            breath_q <= breath_d;
            ps_q     <= ps_d;
        end
    end

    assign cnt          = cnt_q;
    assign period_start = ps_q;

endmodule

// File: rtl/pwm_multi.sv
// NCH-channel PWM LED driver: shadowed duty/mode per channel, applied at period boundaries,
// with an optional triangle-ramp breathe mode.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned NCH        = 3,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned BREATH_DIV = 4,
    parameter int unsigned STEP       = 1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    pwm_multi_if.slave bus
);
    localparam logic [WIDTH:0] DUTY_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] cnt;
    logic             boundary;
    logic             breath_tick;
    logic             period_start;
    logic             wr_ok;
    logic [NCH-1:0]   pwm_on;
    logic [NCH-1:0]   pwm_d, pwm_q;

    pwm_timebase #(
        .PRESCALE  (PRESCALE),
        .WIDTH     (WIDTH),
        .BREATH_DIV(BREATH_DIV)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt),
        .boundary    (boundary),
        .breath_tick (breath_tick),
        .period_start(period_start)
    );

    assign wr_ok = bus.wr_en && (32'(bus.wr_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
        logic             shadow_mode_q, shadow_mode_d;
        logic [WIDTH-1:0] active_duty_q, active_duty_d;
        logic             mode_q, mode_d;
        dir_e             dir_q, dir_d;
        logic [WIDTH:0]   up_sum;

        // One extra bit so the ramp saturates instead of wrapping.
        assign up_sum = {1'b0, active_duty_q} + STEP_EXT;

        always_comb begin
            shadow_duty_d = shadow_duty_q;
            shadow_mode_d = shadow_mode_q;
            active_duty_d = active_duty_q;
            mode_d        = mode_q;
            dir_d         = dir_q;
            if (wr_ok && (32'(bus.wr_ch) == i)) begin
                shadow_duty_d = bus.wr_duty;
                shadow_mode_d = bus.wr_mode;
            end
            // Shadow values read here are the pre-edge ones, so a boundary-cycle write waits.
            if (boundary) begin
                if (shadow_mode_q == MODE_STATIC) begin
                    active_duty_d = shadow_duty_q;
                    mode_d        = MODE_STATIC;
                end else if (mode_q == MODE_STATIC) begin
                    active_duty_d = shadow_duty_q;
                    mode_d        = MODE_BREATHE;
                    dir_d         = DIR_UP;
                end else if (breath_tick) begin
                    if (dir_q == DIR_UP) begin
                        if (up_sum >= DUTY_MAX) begin
                            active_duty_d = '1;
                            dir_d         = DIR_DOWN;
                        end else begin
                            active_duty_d = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, active_duty_q} <= STEP_EXT) begin
                            active_duty_d = '0;
                            dir_d         = DIR_UP;
                        end else begin
                            active_duty_d = active_duty_q - STEP_EXT[WIDTH-1:0];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_duty_q <= '0;
                shadow_mode_q <= MODE_STATIC;
                active_duty_q <= '0;
                mode_q        <= MODE_STATIC;
                dir_q         <= DIR_UP;
            end else begin
                shadow_duty_q <= shadow_duty_d;
                shadow_mode_q <= shadow_mode_d;
                active_duty_q <= active_duty_d;
                mode_q        <= mode_d;
                dir_q         <= dir_d;
            end
        end

        assign pwm_on[i] = (cnt < active_duty_q);
    end

    always_comb begin
        pwm_d = pwm_on ^ {NCH{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= {NCH{ACTIVE_LOW}};
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start;

endmodule
